// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic {
        PREF_ALU,
        PREF_MEM
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_ALU  = 2'b01,
        GNT_MEM  = 2'b10
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; grant is combinational from the current preference.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_alu_i,
    input  logic   req_mem_i,
    output grant_t gnt_o
);

    arb_state_t state_q, state_d;

    always_comb begin
        gnt_o   = GNT_NONE;
        state_d = state_q;
        if (!reset) begin
            if (req_alu_i && (!req_mem_i || state_q == PREF_ALU)) begin
                gnt_o = GNT_ALU;
            end else if (req_mem_i) begin
                gnt_o = GNT_MEM;
            end
        end
        // The granted side loses preference for the next tie.
        unique case (gnt_o)
            GNT_ALU: state_d = PREF_MEM;
            GNT_MEM: state_d = PREF_ALU;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PREF_ALU;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback and tracks
// in-flight destinations in a pending-write scoreboard.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     aluValid,
    input  logic [ADDR_WIDTH-1:0]    aluReg,
    input  logic [DATA_WIDTH-1:0]    aluData,
    output logic                     aluReady,
    input  logic                     memValid,
    input  logic [ADDR_WIDTH-1:0]    memReg,
    input  logic [DATA_WIDTH-1:0]    memData,
    output logic                     memReady,
    input  logic                     issueValid,
    input  logic [ADDR_WIDTH-1:0]    issueReg,
    output logic                     issueReady,
    output logic [2**ADDR_WIDTH-1:0] pendingMask,
    output logic                     writeEnable,
    output logic [ADDR_WIDTH-1:0]    writeReg,
    output logic [DATA_WIDTH-1:0]    writeData
);
    import regfile_pkg::*;

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    grant_t                gnt;
    logic [ADDR_WIDTH-1:0] gnt_reg;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_alu_i (aluValid),
        .req_mem_i (memValid),
        .gnt_o     (gnt)
    );

    assign aluReady   = (gnt == GNT_ALU);
    assign memReady   = (gnt == GNT_MEM);
    assign issueReady = !reset && ((issueReg == '0) || !pend_q[issueReg]);

    always_comb begin
        gnt_reg  = aluReg;
        gnt_data = aluData;
        if (gnt == GNT_MEM) begin
            gnt_reg  = memReg;
            gnt_data = memData;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        if (gnt != GNT_NONE) begin
            // Register 0 is hardwired: accept the request but never strobe the file.
            we_d            = (gnt_reg != '0);
            wreg_d          = gnt_reg;
            wdata_d         = gnt_data;
            pend_d[gnt_reg] = 1'b0;
        end
        // A new producer issuing this cycle overrides a retiring one to the same reg.
        if (issueValid && issueReady) begin
            pend_d[issueReg] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign writeEnable = we_q;
    assign writeReg    = wreg_q;
    assign writeData   = wdata_q;
    assign pendingMask = pend_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a behavioural model of the
// arbitration, write-port latency and scoreboard rules.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        aluValid, memValid, issueValid;
    logic [4:0]  aluReg, memReg, issueReg;
    logic [31:0] aluData, memData;
    logic        aluReady, memReady, issueReady;
    logic [31:0] pendingMask;
    logic        writeEnable;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    regfile_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .aluValid    (aluValid),
        .aluReg      (aluReg),
        .aluData     (aluData),
        .aluReady    (aluReady),
        .memValid    (memValid),
        .memReg      (memReg),
        .memData     (memData),
        .memReady    (memReady),
        .issueValid  (issueValid),
        .issueReg    (issueReg),
        .issueReady  (issueReady),
        .pendingMask (pendingMask),
        .writeEnable (writeEnable),
        .writeReg    (writeReg),
        .writeData   (writeData)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    bit          alu_turn;      // 1: ALU wins a tie
    bit          pend_m [32];
    bit          exp_we;
    bit          wr_known;      // writeReg/writeData value is pinned down by the rules
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) if (pend_m[i]) v = v | (32'd1 << i);
        return v;
    endfunction

    function automatic logic [4:0] rand_reg();
        if ($urandom % 4 == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        bit g_alu, g_mem, i_rdy;
        logic [4:0] g_reg;
        logic [31:0] g_data;

        reset = 1'b1;
        aluValid = 1'b0; memValid = 1'b0; issueValid = 1'b0;
        aluReg = '0; memReg = '0; issueReg = '0;
        aluData = '0; memData = '0;

        alu_turn = 1'b1;
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        exp_we = 1'b0; wr_known = 1'b1; exp_wreg = '0; exp_wdata = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g_alu = 1'b0; g_mem = 1'b0;
            if (!reset) begin
                if (aluValid && memValid) begin
                    g_alu = alu_turn; g_mem = !alu_turn;
                end else begin
                    g_alu = aluValid; g_mem = memValid;
                end
            end
            i_rdy = !reset && (issueReg == 0 || !pend_m[issueReg]);

            check_eq("aluReady", aluReady, g_alu);
            check_eq("memReady", memReady, g_mem);
            check_eq("issueReady", issueReady, i_rdy);
            check_eq("writeEnable", writeEnable, exp_we);
            check_eq("pendingMask", pendingMask, pend_vec());
            if (wr_known) begin
                check_eq("writeReg", writeReg, exp_wreg);
                check_eq("writeData", writeData, exp_wdata);
            end

            @(posedge clk);
            if (reset) begin
                alu_turn = 1'b1;
                foreach (pend_m[i]) pend_m[i] = 1'b0;
                exp_we = 1'b0; wr_known = 1'b1; exp_wreg = '0; exp_wdata = '0;
            end else begin
                exp_we = 1'b0;
                if (g_alu || g_mem) begin
                    g_reg  = g_alu ? aluReg : memReg;
                    g_data = g_alu ? aluData : memData;
                    alu_turn = g_mem;
                    if (g_reg != 0) begin
                        exp_we = 1'b1; wr_known = 1'b1;
                        exp_wreg = g_reg; exp_wdata = g_data;
                        pend_m[g_reg] = 1'b0;
                    end else begin
                        wr_known = 1'b0;
                    end
                end
                if (issueValid && i_rdy && issueReg != 0) pend_m[issueReg] = 1'b1;
            end

            #1;
            if (g_alu) aluValid = 1'b0;
            if (g_mem) memValid = 1'b0;
            if (!aluValid && $urandom % 10 < 6) begin
                aluValid = 1'b1; aluReg = rand_reg(); aluData = $urandom;
            end
            if (!memValid && $urandom % 10 < 6) begin
                memValid = 1'b1; memReg = rand_reg(); memData = $urandom;
            end
            issueValid = ($urandom % 2 == 0);
            issueReg   = rand_reg();
            reset      = (cyc < 2) || ($urandom % 60 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
